// File: rtl/traffic_pkg.sv
// Shared types and defaults for the intersection vehicle model.
// Lane FSM states plus default queue depth and departure timing.
package traffic_pkg;

  localparam int MAX_Q_DEF         = 15;
  localparam int START_DELAY_DEF   = 3;
  localparam int DEPART_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RED,
    START,
    FLOW
  } lane_state_t;

endpackage

// File: rtl/lane_queue.sv
// One lane of the intersection: car queue, release FSM and timer.
// Conflict freezes the timer but only a red light leaves START/FLOW.
module lane_queue
  import traffic_pkg::*;
#(
  parameter int MAX_Q         = MAX_Q_DEF,
  parameter int CNT_W         = $clog2(MAX_Q + 1),
  parameter int START_DELAY   = START_DELAY_DEF,
  parameter int DEPART_CYCLES = DEPART_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_arrive,
  input  logic             i_light,
  input  logic             i_conflict,
  output logic [CNT_W-1:0] o_count,
  output logic             o_depart,
  output logic             o_overflow
);

  localparam int TMAX = (START_DELAY > DEPART_CYCLES) ?
                        START_DELAY : DEPART_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  lane_state_t      r_state;
  lane_state_t      w_state_nxt;
  logic [TW-1:0]    r_tmr;
  logic [TW-1:0]    w_tmr_nxt;
  logic [TW-1:0]    w_tmr_last;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_depart;
  logic             r_overflow;
  logic             w_green;
  logic             w_dep;
  logic             w_acc;
  logic             w_drop;

  assign w_green    = i_light & ~i_conflict;
  assign w_tmr_last = (r_state == START) ?
                      TW'(START_DELAY - 1) :
                      TW'(DEPART_CYCLES - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_dep       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_arrive) begin
          w_state_nxt = w_green ? START : RED;
          w_tmr_nxt   = '0;
        end
      end
      RED: begin
        if (w_green) begin
          w_state_nxt = START;
          w_tmr_nxt   = '0;
        end
      end
      START, FLOW: begin
        if (!i_light) begin
          w_state_nxt = RED;
          w_tmr_nxt   = '0;
        end else if (!i_conflict) begin
          if (r_tmr == w_tmr_last) begin
            w_dep       = 1'b1;
            w_tmr_nxt   = '0;
            w_state_nxt = FLOW;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
          end
        end
      end
    endcase
    // A full queue still accepts a car on a departure edge
    w_acc  = i_arrive & ((r_count != CNT_W'(MAX_Q)) | w_dep);
    w_drop = i_arrive & ~w_acc;
    w_count_nxt = r_count + CNT_W'(w_acc) - CNT_W'(w_dep);
    if (r_state != IDLE && w_count_nxt == '0)
      w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_count    <= '0;
      r_depart   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_count    <= w_count_nxt;
      r_depart   <= w_dep;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign o_count    = r_count;
  assign o_depart   = r_depart;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/intersection_traffic_model.sv
// Vehicle-side model of a two-way intersection driving car sensors.
// Holds the light-conflict detector and the two lane queues.
module intersection_traffic_model
  import traffic_pkg::*;
#(
  parameter int MAX_Q         = MAX_Q_DEF,
  parameter int CNT_W         = $clog2(MAX_Q + 1),
  parameter int START_DELAY   = START_DELAY_DEF,
  parameter int DEPART_CYCLES = DEPART_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ew_arrive,
  input  logic             ns_arrive,
  input  logic             EWLite,
  input  logic             NSLite,
  output logic             EWCar,
  output logic             NSCar,
  output logic [CNT_W-1:0] ew_count,
  output logic [CNT_W-1:0] ns_count,
  output logic             ew_depart,
  output logic             ns_depart,
  output logic             ew_overflow,
  output logic             ns_overflow,
  output logic             conflict
);

  logic w_conflict_now;
  logic r_conflict;

  assign w_conflict_now = EWLite & NSLite;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_conflict <= 1'b0;
    else if (w_conflict_now)
      r_conflict <= 1'b1;
  end

  lane_queue #(
    .MAX_Q        (MAX_Q),
    .CNT_W        (CNT_W),
    .START_DELAY  (START_DELAY),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_ew (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_arrive  (ew_arrive),
    .i_light   (EWLite),
    .i_conflict(w_conflict_now),
    .o_count   (ew_count),
    .o_depart  (ew_depart),
    .o_overflow(ew_overflow)
  );

  lane_queue #(
    .MAX_Q        (MAX_Q),
    .CNT_W        (CNT_W),
    .START_DELAY  (START_DELAY),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_ns (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_arrive  (ns_arrive),
    .i_light   (NSLite),
    .i_conflict(w_conflict_now),
    .o_count   (ns_count),
    .o_depart  (ns_depart),
    .o_overflow(ns_overflow)
  );

  assign EWCar    = (ew_count != '0);
  assign NSCar    = (ns_count != '0);
  assign conflict = r_conflict;

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Directed bench for the intersection vehicle model.
// Expected values are hand-derived from the default timing (3/2/15).
module tb_intersection_traffic_model;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ew_arrive, ns_arrive;
  logic       EWLite, NSLite;
  logic       EWCar, NSCar;
  logic [3:0] ew_count, ns_count;
  logic       ew_depart, ns_depart;
  logic       ew_overflow, ns_overflow;
  logic       conflict;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intersection_traffic_model dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ew_arrive  (ew_arrive),
    .ns_arrive  (ns_arrive),
    .EWLite     (EWLite),
    .NSLite     (NSLite),
    .EWCar      (EWCar),
    .NSCar      (NSCar),
    .ew_count   (ew_count),
    .ns_count   (ns_count),
    .ew_depart  (ew_depart),
    .ns_depart  (ns_depart),
    .ew_overflow(ew_overflow),
    .ns_overflow(ns_overflow),
    .conflict   (conflict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    do_reset();
    obs = {ew_count, ns_count, EWCar, NSCar, ew_depart,
           ns_depart, ew_overflow, ns_overflow, conflict};
    checks++;
    if (obs !== 15'b0) begin
      failures++;
      $display("FAIL reset_init got=%h want=0", obs);
    end
    ew_arrive = 1; ns_arrive = 1; EWLite = 1; NSLite = 1;
    step();
    EWLite = 0; NSLite = 0;
    step();
    checks++;
    if (ew_count !== 4'd2 || ns_count !== 4'd2 || conflict !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got=%0d/%0d/%b want=2/2/1",
               ew_count, ns_count, conflict);
    end
    rst_n = 1'b0;
    step();
    obs = {ew_count, ns_count, EWCar, NSCar, ew_depart,
           ns_depart, ew_overflow, ns_overflow, conflict};
    checks++;
    if (obs !== 15'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h want=0", obs);
    end
    checks++;
    if (dut.u_ew.r_state !== IDLE || dut.u_ns.r_state !== IDLE) begin
      failures++;
      $display("FAIL reset_fsm got=%0d/%0d want=0/0",
               dut.u_ew.r_state, dut.u_ns.r_state);
    end
    rst_n = 1; ew_arrive = 0; ns_arrive = 0;
    step();
  endtask

  task automatic test_queue_red();
    for (int i = 0; i < 3; i++) begin
      ew_arrive = 1;
      step();
      checks++;
      if (ew_count !== 4'(i + 1) || EWCar !== 1'b1 || ew_depart !== 1'b0) begin
        failures++;
        $display("FAIL queue_red[%0d] got=%0d/%b/%b want=%0d/1/0",
                 i, ew_count, EWCar, ew_depart, i + 1);
      end
    end
    ew_arrive = 0;
    step();
    checks++;
    if (ew_count !== 4'd3 || NSCar !== 1'b0) begin
      failures++;
      $display("FAIL queue_hold got=%0d/%b want=3/0", ew_count, NSCar);
    end
  endtask

  task automatic test_release();
    logic       exp_dep;
    logic [3:0] exp_cnt;
    EWLite = 1;
    step();
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_dep = (e == 3 || e == 5 || e == 7);
      exp_cnt = 4'd3 - 4'(e >= 3) - 4'(e >= 5) - 4'(e >= 7);
      checks++;
      if (ew_depart !== exp_dep || ew_count !== exp_cnt) begin
        failures++;
        $display("FAIL release_e%0d got=%b/%0d want=%b/%0d",
                 e, ew_depart, ew_count, exp_dep, exp_cnt);
      end
    end
    checks++;
    if (EWCar !== 1'b0) begin
      failures++;
      $display("FAIL release_car got=%b want=0", EWCar);
    end
    EWLite = 0;
    step();
  endtask

  task automatic test_overflow();
    logic [3:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      ew_arrive = 1;
      step();
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      checks++;
      if (ew_count !== exp_cnt || ew_overflow !== (i == 16)) begin
        failures++;
        $display("FAIL overflow_a%0d got=%0d/%b want=%0d/%b",
                 i, ew_count, ew_overflow, exp_cnt, (i == 16));
      end
    end
    ew_arrive = 0;
    EWLite = 1;
    step();
    step();
    step();
    ew_arrive = 1;
    step();
    checks++;
    if (ew_count !== 4'd15 || ew_depart !== 1'b1 || ew_overflow !== 1'b1) begin
      failures++;
      $display("FAIL arrive_on_depart got=%0d/%b/%b want=15/1/1",
               ew_count, ew_depart, ew_overflow);
    end
    ew_arrive = 0;
    EWLite = 0;
    step();
  endtask

  task automatic test_red_mid();
    do_reset();
    ew_arrive = 1;
    step();
    step();
    ew_arrive = 0;
    EWLite = 1;
    step();
    step();
    EWLite = 0;
    for (int e = 2; e <= 4; e++) begin
      step();
      checks++;
      if (ew_count !== 4'd2 || ew_depart !== 1'b0 ||
          dut.u_ew.r_state !== RED) begin
        failures++;
        $display("FAIL red_mid_e%0d got=%0d/%b/%0d want=2/0/1",
                 e, ew_count, ew_depart, dut.u_ew.r_state);
      end
    end
    EWLite = 1;
    step();
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (ew_depart !== (e == 3) || ew_count !== ((e == 3) ? 4'd1 : 4'd2)) begin
        failures++;
        $display("FAIL regreen_e%0d got=%b/%0d want=%b", e,
                 ew_depart, ew_count, (e == 3));
      end
    end
    EWLite = 0;
    step();
  endtask

  task automatic test_conflict();
    do_reset();
    ew_arrive = 1; ns_arrive = 1;
    step();
    step();
    ew_arrive = 0; ns_arrive = 0;
    EWLite = 1;
    step();
    step();
    NSLite = 1;
    for (int e = 2; e <= 4; e++) begin
      step();
      checks++;
      if (ew_depart !== 1'b0 || ns_depart !== 1'b0 || conflict !== 1'b1 ||
          ew_count !== 4'd2 || ns_count !== 4'd2) begin
        failures++;
        $display("FAIL conflict_e%0d got=%b%b%b/%0d/%0d want=001/2/2",
                 e, ew_depart, ns_depart, conflict, ew_count, ns_count);
      end
    end
    NSLite = 0;
    step();
    checks++;
    if (ew_depart !== 1'b0 || ew_count !== 4'd2) begin
      failures++;
      $display("FAIL conflict_e5 got=%b/%0d want=0/2", ew_depart, ew_count);
    end
    step();
    checks++;
    if (ew_depart !== 1'b1 || ew_count !== 4'd1 || conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_resume got=%b/%0d/%b want=1/1/1",
               ew_depart, ew_count, conflict);
    end
    EWLite = 0;
    NSLite = 1;
    step();
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (ns_depart !== (e == 3) || ew_depart !== 1'b0 ||
          ns_count !== ((e == 3) ? 4'd1 : 4'd2)) begin
        failures++;
        $display("FAIL ns_release_e%0d got=%b/%b/%0d want=%b/0",
                 e, ns_depart, ew_depart, ns_count, (e == 3));
      end
    end
    NSLite = 0;
    step();
  endtask

  initial begin
    rst_n = 0;
    ew_arrive = 0; ns_arrive = 0;
    EWLite = 0; NSLite = 0;
    test_reset();
    test_queue_red();
    test_release();
    test_overflow();
    test_red_mid();
    test_conflict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
